llr_combine_buffer: RTL and testbench
=====================================

# llr_combine_buffer

Soft-combining LLR buffer that sits directly downstream of the post-FFT chain. It captures the rate-matched channel LLR stream: one LLR per write, addressed by memory, word and slot. Repeated code-bit positions are combined by saturating addition into a 512-entry mother-code buffer. Once the frame is complete, the buffer presents it to the polar decoder through a registered 4-LLR-per-word read port. Positions that were never written read back as 0 (erasure).

## Interface
Parameters:
- LLR_WIDTH, 8, signed two's-complement width of one LLR
- WADDR_WIDTH, 6, word address width per memory (64 words x 4 LLRs per memory)
- CNT_WIDTH, 10, width of the combine counter

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- llrs  input  LLR_WIDTH  signed LLR to store
- llr_mem_w_addr  input  WADDR_WIDTH  word address of the write
- mem_llr_slct  input  2  LLR slot within the word (0..3)
- llr_mem_1_w_enable  input  1  write strobe for memory 1
- llr_mem_2_w_enable  input  1  write strobe for memory 2
- llr_done  input  1  pulse: last LLR of the frame has been written
- dec_rd_en  input  1  decoder read request
- dec_rd_addr  input  WADDR_WIDTH+1  MSB selects the memory (0 = mem 1, 1 = mem 2); the LSBs are the word address
- dec_done  input  1  pulse: decoder has finished with the frame
- buf_ready  output  1  level: frame is complete and readable
- dec_rd_data  output  4*LLR_WIDTH  slot k is at [k*LLR_WIDTH +: LLR_WIDTH]
- dec_rd_valid  output  1  dec_rd_data is valid this cycle
- wr_err  output  1  sticky error flag, cleared only by rst or dec_done
- combine_cnt  output  CNT_WIDTH  number of combined (repeated-position) writes in the current frame

## Operation
- Storage is 2 x 64 x 4 LLR registers plus a 512-bit written-bitmap, one bit per position.
- The FSM has two states, FILL (reset state) and READY.
- FILL, write with exactly one enable high:
  - Position = {memory, word, slot}.
  - If the bitmap bit is 0: store llrs and set the bit.
  - If the bitmap bit is 1: store sat(stored + llrs) and increment combine_cnt. combine_cnt saturates at all-ones.
- Saturating add: compute the sum at LLR_WIDTH+1 bits, then clip to [-2^(LLR_WIDTH-1), 2^(LLR_WIDTH-1)-1]. For 8-bit LLRs that range is -128..127.
- Both enables high in the same cycle: no write happens and wr_err is set.
- FILL to READY on llr_done. A write in the same cycle as llr_done is still performed.
- READY:
  - Any write enable sets wr_err; the write is dropped and storage is unchanged.
  - llr_done is ignored.
- READY, dec_rd_en:
  - Next cycle: dec_rd_valid = 1 and dec_rd_data = the addressed word.
  - Each slot whose bitmap bit is 0 reads as 0.
- In FILL, dec_rd_en is ignored and dec_rd_valid stays 0.
- READY to FILL on dec_done. On that transition: bitmap cleared, combine_cnt = 0, wr_err = 0. LLR data registers need not be cleared.
- A read issued in the same cycle as dec_done is still served from the pre-clear contents.
- dec_done in FILL is ignored.

## Timing
- Reset values of every output:
  - buf_ready = 0
  - dec_rd_valid = 0
  - dec_rd_data = 0
  - wr_err = 0
  - combine_cnt = 0
  - Bitmap all 0; state FILL.
- A write at edge N is visible to a read issued at edge N+1 or later.
- A back-to-back write to the same position combines with the previous value; there is no read-modify-write hazard.
- buf_ready rises 1 cycle after the llr_done edge and falls 1 cycle after the dec_done edge.
- Read latency is 1 cycle:
  - dec_rd_data and dec_rd_valid are registered; one read per cycle at full throughput.
  - dec_rd_valid is low in any cycle without a served request.
  - dec_rd_data holds its last value when not reading.
- Reset asserted mid-frame: immediate return to FILL with all reset values; the partial frame is discarded.

## Test plan
- Fill without repetition:
  - Stimulus: write mem 1, word 5, slot 2 = +37 and mem 2, word 63, slot 3 = -100; then llr_done; then read addr 0x05 and 0x7F.
  - Response: buf_ready = 1 one cycle after llr_done. addr 0x05 returns slot 2 = 37 with other slots 0. addr 0x7F returns slot 3 = -100. Each dec_rd_valid is 1 cycle after its dec_rd_en. combine_cnt = 0.
- Combining and saturation:
  - Stimulus: mem 1, word 0, slot 0 written +100 then +50, back-to-back. Slot 1 written -90 then -60. Slot 2 written +20 then -30.
  - Response: read returns 127, -128, -10. combine_cnt = 3.
- Error cases:
  - Stimulus: both enables high with +5 to mem 1, word 1, slot 0; later, a write while READY.
  - Response: the position reads 0 and wr_err = 1. The READY write leaves storage unchanged.
- Frame turnaround:
  - Stimulus: dec_done with a read in the same cycle, then a new write of +7 to the same position as an earlier +40.
  - Response: the same-cycle read returns the old data. After dec_done: buf_ready = 0, wr_err = 0, combine_cnt = 0. The new frame reads back 7, not 47.
- Boundary:
  - Stimulus: dec_rd_en while in FILL; dec_done while in FILL; llr_done together with a final write.
  - Response: no dec_rd_valid; no state change on dec_done; the final write is present after READY.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously after 100 writes.
  - Response: all outputs are at their reset values immediately. After release, a subsequent frame reads only newly written positions.

Source files
------------

// File: rtl/llr_combine_buffer.sv
// Soft-combining LLR buffer: saturating accumulation of repeated code-bit positions
// into a 512-entry mother-code store, read out 4 LLRs per word once the frame is complete.
module llr_combine_buffer #(
    parameter int LLR_WIDTH   = 8,
    parameter int WADDR_WIDTH = 6,
    parameter int CNT_WIDTH   = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [LLR_WIDTH-1:0]   llrs,
    input  logic [WADDR_WIDTH-1:0]        llr_mem_w_addr,
    input  logic [1:0]                    mem_llr_slct,
    input  logic                          llr_mem_1_w_enable,
    input  logic                          llr_mem_2_w_enable,
    input  logic                          llr_done,
    input  logic                          dec_rd_en,
    input  logic [WADDR_WIDTH:0]          dec_rd_addr,
    input  logic                          dec_done,
    output logic                          buf_ready,
    output logic [4*LLR_WIDTH-1:0]        dec_rd_data,
    output logic                          dec_rd_valid,
    output logic                          wr_err,
    output logic [CNT_WIDTH-1:0]          combine_cnt
);

    localparam int IDX_W = WADDR_WIDTH + 3;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [LLR_WIDTH-1:0] LLR_MAX = {1'b0, {(LLR_WIDTH-1){1'b1}}};
    localparam logic [LLR_WIDTH-1:0] LLR_MIN = {1'b1, {(LLR_WIDTH-1){1'b0}}};

    typedef enum logic {FILL, READY} state_t;

    state_t               state, state_next;
    logic                 frame_clear;
    logic [LLR_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]     written;

    logic                 wr_en, wr_hit;
    logic [IDX_W-1:0]     wr_idx;
    logic [LLR_WIDTH-1:0] stored, sat_sum, wr_data;
    logic [LLR_WIDTH:0]   sum;
    logic [4*LLR_WIDTH-1:0] rd_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        frame_clear = 1'b0;
        case (state)
            FILL:  if (llr_done) state_next = READY;
            READY: if (dec_done) begin
                state_next  = FILL;
                frame_clear = 1'b1;
            end
            default: state_next = FILL;
        endcase
    end

    assign buf_ready = (state == READY);

    // Enable 2 doubles as the memory-select bit of the flat position index.
    assign wr_en   = (state == FILL) && (llr_mem_1_w_enable ^ llr_mem_2_w_enable);
    assign wr_idx  = {llr_mem_2_w_enable, llr_mem_w_addr, mem_llr_slct};
    assign wr_hit  = written[wr_idx];
    assign stored  = mem[wr_idx];

    // Sign-extend both operands by one bit; overflow shows as disagreeing top bits.
    assign sum     = {stored[LLR_WIDTH-1], stored} + {llrs[LLR_WIDTH-1], llrs};
    assign sat_sum = (sum[LLR_WIDTH] != sum[LLR_WIDTH-1]) ? (sum[LLR_WIDTH] ? LLR_MIN : LLR_MAX)
                                                          : sum[LLR_WIDTH-1:0];
    assign wr_data = wr_hit ? sat_sum : llrs;

    // NOTE: the LLR store has no reset; the written-bitmap masks stale entries instead.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written     <= '0;
            combine_cnt <= '0;
            wr_err      <= 1'b0;
        end else begin
            if (frame_clear) begin
                written     <= '0;
                combine_cnt <= '0;
            end else if (wr_en) begin
                written[wr_idx] <= 1'b1;
                if (wr_hit && combine_cnt != '1) combine_cnt <= combine_cnt + 1'b1;
            end

            if (frame_clear)
                wr_err <= 1'b0;
            else if ((llr_mem_1_w_enable && llr_mem_2_w_enable) ||
                     (state == READY && (llr_mem_1_w_enable || llr_mem_2_w_enable)))
                wr_err <= 1'b1;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (written[{dec_rd_addr, 2'(k)}])
                rd_word[k*LLR_WIDTH +: LLR_WIDTH] = mem[{dec_rd_addr, 2'(k)}];
        end
    end

    // Read port samples the pre-clear contents, so a read alongside dec_done is still served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_rd_valid <= 1'b0;
            dec_rd_data  <= '0;
        end else begin
            dec_rd_valid <= (state == READY) && dec_rd_en;
            if (state == READY && dec_rd_en) dec_rd_data <= rd_word;
        end
    end

endmodule

// File: tb/tb_llr_combine_buffer.sv
// Self-checking bench for llr_combine_buffer: directed scenarios plus random frames,
// compared every cycle against a position-array reference model.
module tb_llr_combine_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  llrs;
    logic [5:0]  llr_mem_w_addr;
    logic [1:0]  mem_llr_slct;
    logic        llr_mem_1_w_enable, llr_mem_2_w_enable;
    logic        llr_done, dec_rd_en, dec_done;
    logic [6:0]  dec_rd_addr;
    logic        buf_ready, dec_rd_valid, wr_err;
    logic [31:0] dec_rd_data;
    logic [9:0]  combine_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: one entry per position, plus the expected visible outputs.
    int          m_val [512];
    bit          m_wr  [512];
    int          m_cnt;
    bit          m_err, m_ready, m_valid;
    logic [31:0] m_data;
    string       phase;

    always #5 clk = ~clk;

    llr_combine_buffer dut (
        .clk(clk), .rst(rst), .llrs(llrs),
        .llr_mem_w_addr(llr_mem_w_addr), .mem_llr_slct(mem_llr_slct),
        .llr_mem_1_w_enable(llr_mem_1_w_enable), .llr_mem_2_w_enable(llr_mem_2_w_enable),
        .llr_done(llr_done), .dec_rd_en(dec_rd_en), .dec_rd_addr(dec_rd_addr),
        .dec_done(dec_done), .buf_ready(buf_ready), .dec_rd_data(dec_rd_data),
        .dec_rd_valid(dec_rd_valid), .wr_err(wr_err), .combine_cnt(combine_cnt)
    );

    function automatic int sat(input int a);
        if (a > 127)  return 127;
        if (a < -128) return -128;
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("buf_ready",    32'(buf_ready),    32'(m_ready));
        check("dec_rd_valid", 32'(dec_rd_valid), 32'(m_valid));
        check("dec_rd_data",  dec_rd_data,       m_data);
        check("wr_err",       32'(wr_err),       32'(m_err));
        check("combine_cnt",  32'(combine_cnt),  32'(m_cnt));
    endtask

    task automatic model_reset();
        foreach (m_wr[i]) m_wr[i] = 1'b0;
        m_cnt = 0; m_err = 0; m_ready = 0; m_valid = 0; m_data = '0;
    endtask

    // One clock cycle: drive all inputs (called at a negedge), advance the model,
    // then check every output shortly after the rising edge.
    task automatic cycle(input bit e1, input bit e2, input int waddr, input int slot,
                         input int val, input bit ldone, input bit rd, input int raddr,
                         input bit ddone);
        int pos;
        llrs = val[7:0]; llr_mem_w_addr = waddr[5:0]; mem_llr_slct = slot[1:0];
        llr_mem_1_w_enable = e1; llr_mem_2_w_enable = e2;
        llr_done = ldone; dec_rd_en = rd; dec_rd_addr = raddr[6:0]; dec_done = ddone;

        m_valid = 1'b0;
        if (rd && m_ready) begin
            m_valid = 1'b1;
            for (int k = 0; k < 4; k++) begin
                pos = raddr * 4 + k;
                m_data[k*8 +: 8] = m_wr[pos] ? 8'(m_val[pos]) : 8'h00;
            end
        end
        if (e1 || e2) begin
            if (m_ready || (e1 && e2)) m_err = 1'b1;
            else begin
                pos = (e2 ? 256 : 0) + waddr * 4 + slot;
                if (m_wr[pos]) begin
                    m_val[pos] = sat(m_val[pos] + val);
                    if (m_cnt < 1023) m_cnt++;
                end else begin
                    m_val[pos] = val;
                    m_wr[pos]  = 1'b1;
                end
            end
        end
        if (!m_ready && ldone) m_ready = 1'b1;
        else if (m_ready && ddone) begin
            foreach (m_wr[i]) m_wr[i] = 1'b0;
            m_ready = 1'b0; m_cnt = 0; m_err = 1'b0;
        end

        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic wr(input int m, input int waddr, input int slot, input int val);
        cycle(m == 1, m == 2, waddr, slot, val, 0, 0, 0, 0);
    endtask

    task automatic rd(input int raddr);
        cycle(0, 0, 0, 0, 0, 0, 1, raddr, 0);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic done();
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic dec_fin();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        llrs = '0; llr_mem_w_addr = '0; mem_llr_slct = '0;
        llr_mem_1_w_enable = 0; llr_mem_2_w_enable = 0;
        llr_done = 0; dec_rd_en = 0; dec_rd_addr = '0; dec_done = 0;
        model_reset();
        foreach (m_val[i]) m_val[i] = 0;

        phase = "reset";
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        phase = "fill";
        wr(1, 5, 2, 37);
        wr(2, 63, 3, -100);
        done();
        rd(7'h05);
        rd(7'h7F);
        idle();
        dec_fin();

        phase = "combine";
        wr(1, 0, 0, 100);  wr(1, 0, 0, 50);
        wr(1, 0, 1, -90);  wr(1, 0, 1, -60);
        wr(1, 0, 2, 20);   wr(1, 0, 2, -30);
        done();
        rd(7'h00);
        dec_fin();

        phase = "errors";
        cycle(1, 1, 1, 0, 5, 0, 0, 0, 0);
        wr(1, 1, 1, 9);
        done();
        rd(7'h01);
        wr(1, 1, 1, 60);
        wr(2, 1, 1, 3);
        rd(7'h01);
        rd(7'h41);

        phase = "turnaround";
        dec_fin();
        wr(1, 10, 1, 40);
        done();
        cycle(0, 0, 0, 0, 0, 0, 1, 10, 1);
        idle();
        wr(1, 10, 1, 7);
        done();
        rd(10);

        phase = "boundary";
        dec_fin();
        rd(10);
        dec_fin();
        wr(2, 33, 0, -17);
        cycle(0, 1, 33, 1, 126, 1, 0, 0, 0);
        rd(7'h61);
        dec_fin();

        phase = "random";
        for (int i = 0; i < 300; i++) begin
            int e = $urandom_range(0, 20);
            cycle(e != 0 && e < 11, e >= 10, $urandom_range(0, 15), $urandom_range(0, 3),
                  int'($urandom_range(0, 255)) - 128, 0, 0, 0, 0);
        end
        cycle(1, 0, 3, 3, int'($urandom_range(0, 255)) - 128, 1, 0, 0, 0);
        for (int a = 0; a < 128; a++) rd(a);
        cycle(0, 0, 0, 0, 0, 0, 1, 67, 1);

        phase = "reset_mid";
        for (int i = 0; i < 100; i++)
            wr($urandom_range(1, 2), $urandom_range(0, 63), $urandom_range(0, 3),
               int'($urandom_range(0, 255)) - 128);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        wr(1, 3, 3, -5);
        wr(2, 20, 0, 88);
        done();
        for (int a = 0; a < 128; a++) rd(a);
        dec_fin();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
